// File: rtl/ps2_scancode_ctrl.sv
// ps2_scancode_ctrl: turns the PS/2 set-2 byte stream from the receiver FIFO
// into key events (code, E0-extended, break, typematic repeat) with a
// valid/ready output, and tracks caps-lock, a press counter and a sticky error.
// Optional build macro: PS2_TYPEMATIC_FILTER_EN -- when defined, typematic
// repeats of the held key are consumed silently instead of being emitted.
//
// Handshake: an event is transferred in a cycle where evt_valid=1 and
// evt_ready=1; while evt_valid=1 all evt_* outputs hold steady, and evt_ready
// is ignored whenever evt_valid=0. On the input side a byte is consumed in any
// cycle where kbd_ready=1 and kbd_next=1.
module ps2_scancode_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        kbd_ready,
    input  logic [7:0]  kbd_data,
    input  logic        kbd_overflow,
    output logic        kbd_next,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [7:0]  evt_code,
    output logic        evt_ext,
    output logic        evt_break,
    output logic        evt_repeat,
    output logic        caps_lock,
    output logic [15:0] press_cnt,
    output logic        err,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PREFIX = 2'd1,
        BREAK  = 2'd2,
        EMIT   = 2'd3
    } state_t;

    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BRK   = 8'hF0;
    localparam logic [7:0] CODE_CAPS  = 8'h58;

    state_t      state_q, state_d;
    logic        ext_q, ext_d;
    logic        brk_q, brk_d;
    logic [7:0]  code_q, code_d;
    logic        ev_ext_q, ev_ext_d;
    logic        ev_brk_q, ev_brk_d;
    logic        ev_rep_q, ev_rep_d;
    logic        caps_q, caps_d;
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        lm_valid_q, lm_valid_d;
    logic        lm_ext_q, lm_ext_d;
    logic [7:0]  lm_code_q, lm_code_d;

    logic        consume;
    logic        lm_match;
    logic        is_rep;

    // Pop strobe: only outside EMIT and never while reset is asserted.
    assign consume  = kbd_ready && (state_q != EMIT) && !rst;
    assign kbd_next = consume;

    assign lm_match = lm_valid_q && (lm_ext_q == ext_q) && (lm_code_q == kbd_data);
    assign is_rep   = !brk_q && lm_match;

    assign evt_valid   = (state_q == EMIT);
    assign evt_code    = code_q;
    assign evt_ext     = ev_ext_q;
    assign evt_break   = ev_brk_q;
    assign evt_repeat  = ev_rep_q;
    assign caps_lock   = caps_q;
    assign press_cnt   = cnt_q;
    assign err         = err_q;
    assign dbg_state_o = state_q;

    // State and datapath registers, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            code_q     <= 8'h00;
            ev_ext_q   <= 1'b0;
            ev_brk_q   <= 1'b0;
            ev_rep_q   <= 1'b0;
            caps_q     <= 1'b0;
            cnt_q      <= 16'h0000;
            err_q      <= 1'b0;
            lm_valid_q <= 1'b0;
            lm_ext_q   <= 1'b0;
            lm_code_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            code_q     <= code_d;
            ev_ext_q   <= ev_ext_d;
            ev_brk_q   <= ev_brk_d;
            ev_rep_q   <= ev_rep_d;
            caps_q     <= caps_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            lm_valid_q <= lm_valid_d;
            lm_ext_q   <= lm_ext_d;
            lm_code_q  <= lm_code_d;
        end
    end

    // Next-state: byte decode, event latch, last-make tracking and counters.
    always_comb begin
        state_d    = state_q;
        ext_d      = ext_q;
        brk_d      = brk_q;
        code_d     = code_q;
        ev_ext_d   = ev_ext_q;
        ev_brk_d   = ev_brk_q;
        ev_rep_d   = ev_rep_q;
        caps_d     = caps_q;
        cnt_d      = cnt_q;
        err_d      = err_q | kbd_overflow;
        lm_valid_d = lm_valid_q;
        lm_ext_d   = lm_ext_q;
        lm_code_d  = lm_code_q;

        if (state_q == EMIT) begin
            if (evt_ready) begin
                state_d = IDLE;
            end
        end else if (consume) begin
            case (kbd_data)
                CODE_EXT: begin
                    ext_d   = 1'b1;
                    state_d = PREFIX;
                end
                CODE_BRK: begin
                    brk_d   = 1'b1;
                    state_d = BREAK;
                end
                8'hAA, 8'hFA, 8'hFE, 8'hEE: begin
                    // Controller/status replies carry no key information.
                    ext_d   = 1'b0;
                    brk_d   = 1'b0;
                    state_d = IDLE;
                end
                8'h00, 8'hFF: begin
                    // Key-detection error / buffer overrun codes from the keyboard.
                    ext_d   = 1'b0;
                    brk_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
                default: begin
                    // Last-make bookkeeping happens on consumption, regardless of
                    // whether the event is later accepted or filtered.
                    if (!brk_q && !is_rep) begin
                        cnt_d      = cnt_q + 16'd1;
                        lm_valid_d = 1'b1;
                        lm_ext_d   = ext_q;
                        lm_code_d  = kbd_data;
                        if (!ext_q && (kbd_data == CODE_CAPS)) begin
                            caps_d = ~caps_q;
                        end
                    end
                    if (brk_q && lm_match) begin
                        lm_valid_d = 1'b0;
                    end
                    ext_d = 1'b0;
                    brk_d = 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
                    if (is_rep) begin
                        state_d = IDLE;
                    end else begin
                        code_d   = kbd_data;
                        ev_ext_d = ext_q;
                        ev_brk_d = brk_q;
                        ev_rep_d = 1'b0;
                        state_d  = EMIT;
                    end
`else
                    code_d   = kbd_data;
                    ev_ext_d = ext_q;
                    ev_brk_d = brk_q;
                    ev_rep_d = is_rep;
                    state_d  = EMIT;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_scancode_ctrl.sv
// Testbench for ps2_scancode_ctrl: byte-stream reference model with an
// expected-event queue, a vector table of short sequences, hand-written
// multi-cycle sequences and a randomized run.
module tb_ps2_scancode_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        kbd_ready = 1'b0;
  logic [7:0]  kbd_data = 8'h00;
  logic        kbd_overflow = 1'b0;
  logic        kbd_next;
  logic        evt_valid;
  logic        evt_ready = 1'b0;
  logic [7:0]  evt_code;
  logic        evt_ext;
  logic        evt_break;
  logic        evt_repeat;
  logic        caps_lock;
  logic [15:0] press_cnt;
  logic        err;
  logic [1:0]  dbg_state;

  ps2_scancode_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .kbd_ready    (kbd_ready),
    .kbd_data     (kbd_data),
    .kbd_overflow (kbd_overflow),
    .kbd_next     (kbd_next),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_code     (evt_code),
    .evt_ext      (evt_ext),
    .evt_break    (evt_break),
    .evt_repeat   (evt_repeat),
    .caps_lock    (caps_lock),
    .press_cnt    (press_cnt),
    .err          (err),
    .dbg_state_o  (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // stimulus FIFO and consumer mode (0 always ready, 1 random, 2 never)
  logic [7:0]  fifo_q[$];
  int          rdy_mode = 0;

  // reference model state
  logic [10:0] exp_q[$];   // {code, ext, brk, rep}
  bit          m_pending;
  bit          m_ext, m_brk, m_lmv, m_lme, m_caps, m_err;
  logic [7:0]  m_lmc;
  logic [15:0] m_cnt;

  // observed accepted events
  int          n_evt;
  logic [7:0]  last_code;
  logic        last_ext, last_brk, last_rep;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_pending = 0; m_ext = 0; m_brk = 0; m_lmv = 0; m_lme = 0; m_lmc = 8'h00;
    m_caps = 0; m_err = 0; m_cnt = 16'h0000; n_evt = 0;
    last_code = 8'h00; last_ext = 0; last_brk = 0; last_rep = 0;
  endtask

  // Byte-level key decoder model: applies one consumed byte.
  task automatic model_byte(input logic [7:0] b);
    bit rep, match;
    case (b)
      8'hE0: m_ext = 1;
      8'hF0: m_brk = 1;
      8'hAA, 8'hFA, 8'hFE, 8'hEE: begin m_ext = 0; m_brk = 0; end
      8'h00, 8'hFF: begin m_ext = 0; m_brk = 0; m_err = 1; end
      default: begin
        match = m_lmv && (m_lme == m_ext) && (m_lmc == b);
        rep = !m_brk && match;
        if (!m_brk && !rep) begin
          m_cnt = m_cnt + 16'd1;
          if (b == 8'h58 && !m_ext) m_caps = !m_caps;
          m_lmv = 1; m_lme = m_ext; m_lmc = b;
        end
        if (m_brk && match) m_lmv = 0;
`ifdef PS2_TYPEMATIC_FILTER_EN
        if (!rep) begin
          exp_q.push_back({b, m_ext, m_brk, 1'b0});
          m_pending = 1;
        end
`else
        exp_q.push_back({b, m_ext, m_brk, rep});
        m_pending = 1;
`endif
        m_ext = 0; m_brk = 0;
      end
    endcase
  endtask

  task automatic drive();
    kbd_ready = (fifo_q.size() > 0);
    kbd_data  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    case (rdy_mode)
      0: evt_ready = 1'b1;
      1: evt_ready = ($urandom_range(0, 1) == 1);
      default: evt_ready = 1'b0;
    endcase
  endtask

  // One clock: scoreboard checks at negedge, advance model, redrive after posedge.
  task automatic step();
    bit pop, hs, ovf;
    logic [10:0] e;
    @(negedge clk);
    pop = kbd_ready && kbd_next;
    hs  = evt_valid && evt_ready;
    ovf = kbd_overflow;
    chk("kbd_next", kbd_next, kbd_ready && !m_pending);
    chk("evt_valid", evt_valid, m_pending);
    if (m_pending && exp_q.size() > 0) begin
      e = exp_q[0];
      chk("evt_fields", {evt_code, evt_ext, evt_break, evt_repeat}, e);
    end
    chk("caps_lock", caps_lock, m_caps);
    chk("press_cnt", press_cnt, m_cnt);
    chk("err", err, m_err);
    if (hs && m_pending) begin
      void'(exp_q.pop_front());
      m_pending = 0;
      n_evt++;
      last_code = evt_code; last_ext = evt_ext; last_brk = evt_break; last_rep = evt_repeat;
    end
    if (pop) model_byte(kbd_data);
    if (ovf) m_err = 1;
    @(posedge clk); #1;
    if (pop) void'(fifo_q.pop_front());
    kbd_overflow = 1'b0;
    drive();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    drive();
  endtask

  // Reset with a byte offered: no pop allowed, all outputs at reset values.
  task automatic do_reset();
    rst = 1'b1; kbd_ready = 1'b1; kbd_data = 8'h1C; evt_ready = 1'b0; kbd_overflow = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_kbd_next", kbd_next, 0);
    chk("rst_outputs", {evt_valid, evt_code, evt_ext, evt_break, evt_repeat, caps_lock, press_cnt, err},
        '0);
    @(posedge clk); #1;
    rst = 1'b0;
    fifo_q.delete();
    model_reset();
    rdy_mode = 0;
    drive();
  endtask

  typedef struct {
    int          n;
    logic [23:0] bytes;   // first byte in [23:16]
    bit          has_evt;
    logic [7:0]  code;
    bit          ext;
    bit          brk;
    bit          caps;
    logic [15:0] cnt;
    bit          err;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [7:0] pool[10];
    logic [23:0] bs;
    model_reset();

    //        n  bytes        evt code   ext brk caps cnt err
    vecs[0]  = '{1, 24'h1C0000, 1, 8'h1C, 0, 0, 0, 16'd1, 0};
    vecs[1]  = '{3, 24'hE0F075, 1, 8'h75, 1, 1, 0, 16'd0, 0};
    vecs[2]  = '{2, 24'hE07400, 1, 8'h74, 1, 0, 0, 16'd1, 0};
    vecs[3]  = '{2, 24'hF01C00, 1, 8'h1C, 0, 1, 0, 16'd0, 0};
    vecs[4]  = '{1, 24'hAA0000, 0, 8'h00, 0, 0, 0, 16'd0, 0};
    vecs[5]  = '{1, 24'hFA0000, 0, 8'h00, 0, 0, 0, 16'd0, 0};
    vecs[6]  = '{1, 24'hFF0000, 0, 8'h00, 0, 0, 0, 16'd0, 1};
    vecs[7]  = '{1, 24'h000000, 0, 8'h00, 0, 0, 0, 16'd0, 1};
    vecs[8]  = '{3, 24'hE0AA1C, 1, 8'h1C, 0, 0, 0, 16'd1, 0};
    vecs[9]  = '{1, 24'h580000, 1, 8'h58, 0, 0, 1, 16'd1, 0};
    vecs[10] = '{2, 24'hE05800, 1, 8'h58, 1, 0, 0, 16'd1, 0};
    vecs[11] = '{3, 24'hF0E01C, 1, 8'h1C, 1, 1, 0, 16'd0, 0};

    // table-driven vectors, each from reset with an always-ready consumer
    for (int v = 0; v < 12; v++) begin
      do_reset();
      bs = vecs[v].bytes;
      for (int k = 0; k < vecs[v].n; k++) begin
        push(bs[23:16]);
        bs = bs << 8;
      end
      steps(8);
      chk($sformatf("vec%0d_nevt", v), n_evt, vecs[v].has_evt ? 1 : 0);
      if (vecs[v].has_evt)
        chk($sformatf("vec%0d_evt", v), {last_code, last_ext, last_brk, last_rep},
            {vecs[v].code, vecs[v].ext, vecs[v].brk, 1'b0});
      chk($sformatf("vec%0d_caps", v), caps_lock, vecs[v].caps);
      chk($sformatf("vec%0d_cnt", v), press_cnt, vecs[v].cnt);
      chk($sformatf("vec%0d_err", v), err, vecs[v].err);
    end

    // caps-lock toggles twice across make / break / make
    do_reset();
    push(8'h58); steps(4);
    chk("caps_after_make1", caps_lock, 1);
    push(8'hF0); push(8'h58); steps(5);
    chk("caps_after_break", caps_lock, 1);
    push(8'h58); steps(4);
    chk("caps_after_make2", caps_lock, 0);
    chk("caps_press_cnt", press_cnt, 2);

    // typematic: three identical makes
    do_reset();
    push(8'h1C); push(8'h1C); push(8'h1C); steps(10);
`ifdef PS2_TYPEMATIC_FILTER_EN
    chk("rep_nevt", n_evt, 1);
    chk("rep_last_rep", last_rep, 0);
`else
    chk("rep_nevt", n_evt, 3);
    chk("rep_last_rep", last_rep, 1);
`endif
    chk("rep_cnt", press_cnt, 1);

    // consumer stall: second byte must stay queued until the handshake
    do_reset();
    rdy_mode = 2;
    push(8'h1C); push(8'h32);
    steps(11);
    chk("stall_fifo_left", fifo_q.size(), 1);
    chk("stall_code", evt_code, 8'h1C);
    rdy_mode = 0; drive();
    steps(6);
    chk("stall_fifo_empty", fifo_q.size(), 0);
    chk("stall_nevt", n_evt, 2);
    chk("stall_last_code", last_code, 8'h32);

    // reset in PREFIX drops the extension flag
    do_reset();
    push(8'hE0); steps(2);
    do_reset();
    push(8'h1C); steps(4);
    chk("rst_prefix_ext", {last_code, last_ext}, {8'h1C, 1'b0});

    // reset while an event is pending in EMIT (outputs checked in do_reset)
    rdy_mode = 2; drive();
    push(8'h32); steps(3);
    chk("emit_pending_valid", evt_valid, 1);
    do_reset();
    steps(2);

    // error byte, overflow pulse, then reset clears err
    push(8'hFF); steps(3);
    chk("err_after_ff", err, 1);
    kbd_overflow = 1'b1; steps(3);
    chk("err_after_ovf", err, 1);
    do_reset();
    steps(1);
    kbd_overflow = 1'b1; steps(2);
    chk("err_ovf_only", err, 1);

    // randomized run against the model
    do_reset();
    pool = '{8'hE0, 8'hF0, 8'h1C, 8'h1C, 8'h32, 8'h58, 8'h58, 8'h75, 8'hAA, 8'hF0};
    rdy_mode = 1;
    for (int i = 0; i < 4000; i++) begin
      if (fifo_q.size() < 4 && $urandom_range(0, 2) != 0) begin
        if ($urandom_range(0, 499) == 0) push(8'hFF);
        else push(pool[$urandom_range(0, 9)]);
      end
      if ($urandom_range(0, 999) == 0) kbd_overflow = 1'b1;
      step();
    end
    rdy_mode = 0; drive();
    steps(40);
    chk("rand_drain_fifo", fifo_q.size(), 0);
    chk("rand_drain_exp", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
